data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, giving log2 of the word count (256 x 32-bit words).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port nReset, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port MemAddr, input, 16 bits: byte address; [DEPTH_LOG2+1:2] is the word index, [1:0] the byte offset o.
REQ-005 SHALL have port WriteData, input, 32 bits: store data, already lane-aligned by the requester.
REQ-006 SHALL have port MemRead, input, 1 bit: load request.
REQ-007 SHALL have port MemWrite, input, 1 bit: store request.
REQ-008 SHALL have port WriteL, input, 1 bit: store-word-left partial write.
REQ-009 SHALL have port WriteR, input, 1 bit: store-word-right partial write.
REQ-010 SHALL have port MemData, output, 32 bits: registered load data.
REQ-011 SHALL have port Ready, output, 1 bit: high when requests are accepted.
REQ-012 SHALL have port AddrErr, output, 1 bit: sticky out-of-range access flag.
REQ-013 SHALL have port ModeErr, output, 1 bit: sticky flag for WriteL and WriteR both high on a store.
REQ-014 SHALL have port ParityErr, output, 1 bit: one-cycle parity-fail pulse.

Function
REQ-015 SHALL implement FSM states CLEAR and IDLE only.
REQ-016 In CLEAR, SHALL zero one word per cycle, using a counter from 0 to 2^DEPTH_LOG2-1, with Ready=0.
REQ-017 After the final clear write, SHALL enter IDLE next cycle with Ready=1; CLEAR therefore lasts exactly 2^DEPTH_LOG2 cycles.
REQ-018 SHALL ignore MemRead and MemWrite while Ready=0: no write, MemData held, no flags.
REQ-019 A read accepted at edge N SHALL present the addressed word on MemData after edge N, i.e. one-cycle latency.
REQ-020 SHALL hold MemData until the next accepted read.
REQ-021 For a store with WriteL=0 and WriteR=0, SHALL write the full word.
REQ-022 For a store with WriteL=1, SHALL write only bits [31:8*o] from WriteData, keeping all other bits.
REQ-023 For a store with WriteR=1, SHALL write only bits [8*o+7:0], keeping all other bits.
REQ-024 For a store with WriteL=1 and WriteR=1, SHALL write the full word and set ModeErr.
REQ-025 With MemRead and MemWrite both set on the same address, SHALL return the pre-write content on MemData and write the new data (read-before-write).
REQ-026 An access with any of MemAddr[15:DEPTH_LOG2+2] nonzero SHALL be suppressed (no write) and SHALL set AddrErr.
REQ-027 A suppressed out-of-range read SHALL load MemData with 0.
REQ-028 AddrErr and ModeErr SHALL clear only on reset.
REQ-029 Partial-write flags WriteL and WriteR SHALL be ignored when MemWrite=0.

Reset
REQ-030 While nReset=0 at an edge, SHALL set: MemData=0, Ready=0, AddrErr=0, ModeErr=0, ParityErr=0, clear counter=0, state=CLEAR.
REQ-031 Reset asserted mid-CLEAR or mid-operation SHALL restart CLEAR from word 0; storage contents are not otherwise reset.

Configuration
REQ-032 With macro DMEM_PARITY_EN defined, SHALL store one even-parity bit per word, updated on every write including CLEAR and partial writes.
REQ-033 With DMEM_PARITY_EN defined, SHALL check parity on each accepted in-range read and pulse ParityErr high in the cycle MemData updates if parity mismatches.
REQ-034 Without DMEM_PARITY_EN, SHALL have no parity storage and SHALL tie ParityErr to 0; all other behaviour is identical.

Verification
REQ-035 Release reset, then count cycles until Ready=1 -> exactly 256; a read of word 0x3C then returns 0x00000000.
REQ-036 Store 0xDEADBEEF at 0x0010, read 0x0010 the next cycle -> MemData=0xDEADBEEF one cycle after the read request.
REQ-037 Word at 0x0020 = 0x11223344; WriteL store, o=2 (addr 0x0022), data 0xAABBCCDD -> word=0xAABB3344. Then WriteR store, o=1 (addr 0x0021), data 0x55667788 -> word=0xAABB7788.
REQ-038 Read 0x0400 (out of range, DEPTH_LOG2=8) -> MemData=0, AddrErr=1 and stays 1; a store to 0x0400 does not alias word 0.
REQ-039 Assert nReset for one cycle at clear count 100, then release -> Ready=0 for a further full 256 cycles, and all flags=0.
REQ-040 With DMEM_PARITY_EN defined, force a stored-parity flip on word 5 and read 0x0014 -> ParityErr pulses for exactly one cycle.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port 32-bit data memory controller.
// After reset the controller zeroes every word, one word per cycle, and only
// then raises Ready. Loads are registered with one cycle of latency and use
// read-before-write. Stores can be full-word, store-word-left or
// store-word-right. Out-of-range and conflicting partial-write requests set
// sticky error flags.
// Optional feature: define DMEM_PARITY_EN to keep one even-parity bit per word
// and pulse ParityErr on a load that finds a parity mismatch.
module data_mem_ctrl #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] MemAddr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        WriteL,
  input  logic        WriteR,
  output logic [31:0] MemData,
  output logic        Ready,
  output logic        AddrErr,
  output logic        ModeErr,
  output logic        ParityErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_clr_cnt;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_ofs;
  logic [31:0]           w_old;
  logic [31:0]           w_mask;
  logic [31:0]           w_merged;
  logic                  w_par_bad;

  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_waddr;
  logic [31:0]           w_mem_wdata;

  logic [31:0]           r_rd_data_p1;
  logic                  r_par_err_p1;
  logic                  r_addr_err;
  logic                  r_mode_err;

  // Byte lanes a store may touch. Left: lanes o..3; right: lanes 0..o.
  // Neither or both flags set means the full word is written.
  function automatic logic [31:0] lane_mask(input logic       wl,
                                            input logic       wr,
                                            input logic [1:0] ofs);
    logic [4:0] sh;
    sh = {ofs, 3'b000};
    if (wl && !wr)
      lane_mask = 32'hFFFF_FFFF << sh;
    else if (wr && !wl)
      lane_mask = ~(32'hFFFF_FF00 << sh);
    else
      lane_mask = 32'hFFFF_FFFF;
  endfunction

  assign w_idx    = MemAddr[DEPTH_LOG2+1:2];
  assign w_ofs    = MemAddr[1:0];
  assign w_oor    = (MemAddr >> (DEPTH_LOG2 + 2)) != 16'd0;
  assign w_old    = r_mem[w_idx];
  assign w_rd_acc = w_ready && MemRead;
  assign w_wr_acc = w_ready && MemWrite;
  assign w_mask   = lane_mask(WriteL, WriteR, w_ofs);
  assign w_merged = (w_old & ~w_mask) | (WriteData & w_mask);

  // FSM state register; reset always restarts the clear sweep.
  always_ff @(posedge Clock) begin
    if (!nReset)
      r_state <= S_CLEAR;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and Ready decode; IDLE is reached right after the last clear write.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == CNT_MAX)
          w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Clear-sweep word counter, advancing once per CLEAR cycle.
  always_ff @(posedge Clock) begin
    if (!nReset)
      r_clr_cnt <= '0;
    else if (r_state == S_CLEAR)
      r_clr_cnt <= r_clr_cnt + CNT_ONE;
  end

  // Single write port shared by the clear sweep and accepted in-range stores.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_clr_cnt;
    w_mem_wdata = 32'h0000_0000;
    if (nReset) begin
      if (r_state == S_CLEAR) begin
        w_mem_we = 1'b1;
      end else if (w_wr_acc && !w_oor) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_idx;
        w_mem_wdata = w_merged;
      end
    end
  end

  // Storage array; contents are only ever changed through the write port.
  always_ff @(posedge Clock) begin
    if (w_mem_we)
      r_mem[w_mem_waddr] <= w_mem_wdata;
  end

`ifdef DMEM_PARITY_EN
  logic r_par [DEPTH];

  // Even-parity shadow bit, written alongside every data write.
  always_ff @(posedge Clock) begin
    if (w_mem_we)
      r_par[w_mem_waddr] <= ^w_mem_wdata;
  end

  assign w_par_bad = (^w_old) != r_par[w_idx];
`else
  assign w_par_bad = 1'b0;
`endif

  // Load data register and error flags; load returns pre-write content.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_rd_data_p1 <= 32'h0000_0000;
      r_par_err_p1 <= 1'b0;
      r_addr_err   <= 1'b0;
      r_mode_err   <= 1'b0;
    end else begin
      r_par_err_p1 <= 1'b0;
      if (w_rd_acc) begin
        r_rd_data_p1 <= w_oor ? 32'h0000_0000 : w_old;
        r_par_err_p1 <= !w_oor && w_par_bad;
      end
      if ((w_rd_acc || w_wr_acc) && w_oor)
        r_addr_err <= 1'b1;
      if (w_wr_acc && WriteL && WriteR)
        r_mode_err <= 1'b1;
    end
  end

  assign MemData   = r_rd_data_p1;
  assign Ready     = w_ready;
  assign AddrErr   = r_addr_err;
  assign ModeErr   = r_mode_err;
  assign ParityErr = r_par_err_p1;

endmodule
